gpr_writeback_arbiter: RTL and testbench
========================================

# gpr_writeback_arbiter

Writeback-side driver for the dual-write-port general purpose register file of the dual-issue pipeline. Merges in-order results from the two issue pipes with out-of-order results from the long-latency unit (divider/multiplier/miss loads), then drives the register file's two write ports (enable, address, data, debug PC) from registered outputs. Buffers long-latency results, squashes ones overwritten by younger pipe writes, and raises a stall when they starve.

## Interface
Parameters:
- FIFO_DEPTH, 2: long-latency result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4: cycles a buffered result may wait undrained before `wb_stall`

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock, asynchronous and active-high
- wb0_valid / wb1_valid  in  1  pipe 0 / pipe 1 result valid this cycle
- wb0_addr / wb1_addr  in  MipsReg  destination register
- wb0_data / wb1_data  in  32  result value
- wb0_pc / wb1_pc  in  32  instruction PC (debug)
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  buffer can accept; equals "FIFO not full"
- lu_addr / lu_data / lu_pc  in  MipsReg / 32 / 32  long-latency result
- reg_write0 / reg_write1  out  1  register file write enables
- write_addr0 / write_addr1  out  MipsReg  write addresses
- write_data0 / write_data1  out  32  write data
- pc0 / pc1  out  32  PCs for the register file debug print
- wb_stall  out  1  request to the pipeline to send no pipe results next cycle

## Operation
- Pipe results with addr == ZERO are discarded on entry. Long-latency results with addr == ZERO are accepted but never written.
- Port steering, per cycle: wb0 → port 0, wb1 → port 1. Remaining free ports take FIFO entries in order: head first, port 0 preferred. Up to 2 entries drain per cycle when both pipes are idle.
- WAW: if both selected writes in a cycle target the same address, port 0's write is suppressed. Port 1 is always the younger write.
- Squash: a buffered entry, or an entry enqueuing this cycle, whose addr matches a valid pipe write this cycle is marked dead. Pipe results are always younger than any undrained long-latency result. Dead entries are popped without writing and consume no port.
- Starve counter:
  - increments each cycle the FIFO holds a live entry and none drains
  - clears on any drain or when the FIFO is empty
  - when it reaches STARVE_LIMIT, `wb_stall` is registered high for one cycle and the counter clears
- Pipeline contract: wb0_valid = wb1_valid = 0 in the cycle after `wb_stall` = 1. A violation is an assertion failure.
- Simultaneous push and pop on a full FIFO: `lu_ready` is 0, so no push occurs. Pop uses pre-edge contents.

## Timing
- Reset values: all `reg_write*`, `write_addr*`, `write_data*`, `pc*`, and `wb_stall` = 0. FIFO empty, `lu_ready` = 1, starve counter = 0.
- Reset mid-operation discards all buffered results, with no partial write.
- Pipe result at cycle N → write port asserted in cycle N+1 (outputs registered).
- Long-latency handshake (lu_valid & lu_ready) at edge N → entry eligible in cycle N+1 → earliest write port in cycle N+2.
- `lu_ready` is combinational from FIFO occupancy only, not from lu_valid.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits with wrap-around. full = MSB differ and low bits equal.

## Structure
- Shared package: MipsReg and ZERO (existing MipsDefinitions). New struct `wb_req_t` {valid, dead, addr, data, pc}.
- Sub-module `wb_result_fifo`: FIFO_DEPTH-entry circular buffer of `wb_req_t`, with:
  - pop count 0/1/2
  - per-entry address-match kill inputs from the two pipe ports
  - head/next outputs

## Test plan
- Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately, lu_ready = 1.
- wb0 ($5, 0x11111111) and wb1 ($5, 0x22222222) in the same cycle → next cycle reg_write0 = 0, reg_write1 = 1, write_addr1 = 5, data 0x22222222.
- lu ($7, 0xAAAA0000) accepted at cycle 0, pipes idle → reg_write0 = 1, $7 ← 0xAAAA0000 in cycle 2. wb0 ($0) is ignored.
- lu ($9) buffered, then wb1 ($9, 0x5) while both pipes busy → only $9 ← 0x5 is ever written; the entry pops silently.
- Both pipes valid continuously with 1 live entry → wb_stall high in cycle 5 after buffering. The next cycle, with pipes idle, the entry drains on port 0.
- Fill the FIFO with 2 entries → lu_ready = 0. A third lu_valid is held until a pop. Then both pipes idle → both entries drain in one cycle on ports 0/1 in order.

Source files
------------

// File: rtl/gpr_writeback_arbiter_pkg.sv
// Shared writeback types: MIPS register names and the buffered long-latency
// result record used between the arbiter and its result FIFO.
package gpr_writeback_arbiter_pkg;

    typedef enum logic [4:0] {
        ZERO, AT, V0, V1, A0, A1, A2, A3,
        T0, T1, T2, T3, T4, T5, T6, T7,
        S0, S1, S2, S3, S4, S5, S6, S7,
        T8, T9, K0, K1, GP, SP, FP, RA
    } MipsReg;

    typedef struct packed {
        logic        valid;
        logic        dead;
        MipsReg      addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wb_req_t;

    localparam wb_req_t WB_REQ_IDLE = '{valid: 1'b0, dead: 1'b0, addr: ZERO,
                                        data: 32'd0, pc: 32'd0};

    // True when a younger pipe write this cycle targets the same register.
    function automatic logic addr_hit(input MipsReg a,
                                      input logic v0, input MipsReg a0,
                                      input logic v1, input MipsReg a1);
        return (v0 && (a == a0)) || (v1 && (a == a1));
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer of long-latency results with in-place squash marking and
// up to two pops per cycle from the head.
module wb_result_fifo
    import gpr_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  wb_req_t    push_req,
    input  logic [1:0] pop_cnt,
    input  logic       kill0_valid,
    input  MipsReg     kill0_addr,
    input  logic       kill1_valid,
    input  MipsReg     kill1_addr,
    output wb_req_t    head,
    output wb_req_t    next,
    output logic       head_vld,
    output logic       next_vld,
    output logic       full,
    output logic       live_any
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    wb_req_t         mem_q [DEPTH];
    wb_req_t         mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   count;
    logic [AW-1:0]   rd_idx, nx_idx;

    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_idx   = rd_ptr_q[AW-1:0];
    assign nx_idx   = rd_idx + AW'(1);
    assign head_vld = (count != '0);
    assign next_vld = (count > PW'(1));

    // Head/next report a same-cycle pipe hit as dead so it never reaches a port.
    always_comb begin
        head = mem_q[rd_idx];
        next = mem_q[nx_idx];
        head.dead = head.dead | addr_hit(head.addr, kill0_valid, kill0_addr,
                                         kill1_valid, kill1_addr);
        next.dead = next.dead | addr_hit(next.addr, kill0_valid, kill0_addr,
                                         kill1_valid, kill1_addr);
    end

    always_comb begin
        live_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            live_any = live_any | (mem_q[i].valid & ~mem_q[i].dead);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (mem_q[i].valid && addr_hit(mem_q[i].addr, kill0_valid, kill0_addr,
                                           kill1_valid, kill1_addr)) begin
                mem_d[i].dead = 1'b1;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (pop_cnt > 2'(k)) begin
                mem_d[rd_idx + AW'(k)].valid = 1'b0;
            end
        end
        // Push only happens when not full, so the write slot never aliases a pop.
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]]       = push_req;
            mem_d[wr_ptr_q[AW-1:0]].valid = 1'b1;
            mem_d[wr_ptr_q[AW-1:0]].dead  = push_req.dead |
                addr_hit(push_req.addr, kill0_valid, kill0_addr, kill1_valid, kill1_addr);
        end
        rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
        wr_ptr_d = wr_ptr_q + PW'(push);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= WB_REQ_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/gpr_writeback_arbiter.sv
// Drives the two register-file write ports from the issue pipes plus buffered
// long-latency results; registers all port outputs and the starvation stall.
module gpr_writeback_arbiter
    import gpr_writeback_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb0_valid,
    input  MipsReg      wb0_addr,
    input  logic [31:0] wb0_data,
    input  logic [31:0] wb0_pc,
    input  logic        wb1_valid,
    input  MipsReg      wb1_addr,
    input  logic [31:0] wb1_data,
    input  logic [31:0] wb1_pc,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  MipsReg      lu_addr,
    input  logic [31:0] lu_data,
    input  logic [31:0] lu_pc,
    output logic        reg_write0,
    output logic        reg_write1,
    output MipsReg      write_addr0,
    output MipsReg      write_addr1,
    output logic [31:0] write_data0,
    output logic [31:0] write_data1,
    output logic [31:0] pc0,
    output logic [31:0] pc1,
    output logic        wb_stall
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic       p0_v, p1_v, push, full, live_any;
    logic       head_vld, next_vld;
    logic [1:0] pop_cnt;
    wb_req_t    push_req, head, next, sel0, sel1;

    logic        reg_write0_q, reg_write0_d, reg_write1_q, reg_write1_d;
    MipsReg      write_addr0_q, write_addr0_d, write_addr1_q, write_addr1_d;
    logic [31:0] write_data0_q, write_data0_d, write_data1_q, write_data1_d;
    logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic        wb_stall_q, wb_stall_d;
    logic [SW-1:0] starve_q, starve_d;

    assign p0_v     = wb0_valid && (wb0_addr != ZERO);
    assign p1_v     = wb1_valid && (wb1_addr != ZERO);
    assign lu_ready = ~full;
    assign push     = lu_valid && lu_ready;

    always_comb begin
        push_req = '{valid: 1'b1, dead: (lu_addr == ZERO), addr: lu_addr,
                     data: lu_data, pc: lu_pc};
    end

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_req    (push_req),
        .pop_cnt     (pop_cnt),
        .kill0_valid (p0_v),
        .kill0_addr  (wb0_addr),
        .kill1_valid (p1_v),
        .kill1_addr  (wb1_addr),
        .head        (head),
        .next        (next),
        .head_vld    (head_vld),
        .next_vld    (next_vld),
        .full        (full),
        .live_any    (live_any)
    );

    // Pipes own their ports; FIFO entries fill the gaps in order, dead ones pop free.
    always_comb begin
        sel0    = WB_REQ_IDLE;
        sel1    = WB_REQ_IDLE;
        pop_cnt = 2'd0;
        if (p0_v) sel0 = '{valid: 1'b1, dead: 1'b0, addr: wb0_addr, data: wb0_data, pc: wb0_pc};
        if (p1_v) sel1 = '{valid: 1'b1, dead: 1'b0, addr: wb1_addr, data: wb1_data, pc: wb1_pc};
        if (head_vld) begin
            if (head.dead) begin
                pop_cnt = 2'd1;
            end else if (!sel0.valid) begin
                sel0    = head;
                pop_cnt = 2'd1;
            end else if (!sel1.valid) begin
                sel1    = head;
                pop_cnt = 2'd1;
            end
        end
        if (pop_cnt == 2'd1 && next_vld) begin
            if (next.dead) begin
                pop_cnt = 2'd2;
            end else if (!sel0.valid) begin
                sel0    = next;
                pop_cnt = 2'd2;
            end else if (!sel1.valid) begin
                sel1    = next;
                pop_cnt = 2'd2;
            end
        end
    end

    always_comb begin
        reg_write1_d  = sel1.valid && !sel1.dead;
        reg_write0_d  = sel0.valid && !sel0.dead &&
                        !(reg_write1_d && (sel1.addr == sel0.addr));
        write_addr0_d = reg_write0_d ? sel0.addr : ZERO;
        write_data0_d = reg_write0_d ? sel0.data : 32'd0;
        pc0_d         = reg_write0_d ? sel0.pc   : 32'd0;
        write_addr1_d = reg_write1_d ? sel1.addr : ZERO;
        write_data1_d = reg_write1_d ? sel1.data : 32'd0;
        pc1_d         = reg_write1_d ? sel1.pc   : 32'd0;
    end

    always_comb begin
        wb_stall_d = 1'b0;
        if (pop_cnt != 2'd0 || !live_any) begin
            starve_d = '0;
        end else begin
            starve_d = starve_q + SW'(1);
        end
        if (starve_d == SW'(STARVE_LIMIT)) begin
            wb_stall_d = 1'b1;
            starve_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write0_q  <= 1'b0;
            reg_write1_q  <= 1'b0;
            write_addr0_q <= ZERO;
            write_addr1_q <= ZERO;
            write_data0_q <= 32'd0;
            write_data1_q <= 32'd0;
            pc0_q         <= 32'd0;
            pc1_q         <= 32'd0;
            wb_stall_q    <= 1'b0;
            starve_q      <= '0;
        end else begin
            reg_write0_q  <= reg_write0_d;
            reg_write1_q  <= reg_write1_d;
            write_addr0_q <= write_addr0_d;
            write_addr1_q <= write_addr1_d;
            write_data0_q <= write_data0_d;
            write_data1_q <= write_data1_d;
            pc0_q         <= pc0_d;
            pc1_q         <= pc1_d;
            wb_stall_q    <= wb_stall_d;
            starve_q      <= starve_d;
        end
    end

    assign reg_write0  = reg_write0_q;
    assign reg_write1  = reg_write1_q;
    assign write_addr0 = write_addr0_q;
    assign write_addr1 = write_addr1_q;
    assign write_data0 = write_data0_q;
    assign write_data1 = write_data1_q;
    assign pc0         = pc0_q;
    assign pc1         = pc1_q;
    assign wb_stall    = wb_stall_q;

    // The pipeline must honour a stall by sending nothing the following cycle.
    a_stall_honoured: assert property (@(posedge clk) disable iff (rst)
        wb_stall_q |=> !(wb0_valid || wb1_valid))
        else $error("pipe result sent in the cycle after wb_stall");

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Directed bench for gpr_writeback_arbiter: WAW, squash, latency, starvation
// stall, FIFO full back-pressure and asynchronous reset.
module tb_gpr_writeback_arbiter;
    import gpr_writeback_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb0_valid, wb1_valid, lu_valid, lu_ready;
    MipsReg      wb0_addr, wb1_addr, lu_addr, write_addr0, write_addr1;
    logic [31:0] wb0_data, wb1_data, lu_data, wb0_pc, wb1_pc, lu_pc;
    logic        reg_write0, reg_write1, wb_stall;
    logic [31:0] write_data0, write_data1, pc0, pc1;

    int checks = 0;
    int fails  = 0;

    gpr_writeback_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_pc(wb0_pc),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_pc(wb1_pc),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
        .lu_pc(lu_pc),
        .reg_write0(reg_write0), .reg_write1(reg_write1),
        .write_addr0(write_addr0), .write_addr1(write_addr1),
        .write_data0(write_data0), .write_data1(write_data1),
        .pc0(pc0), .pc1(pc1), .wb_stall(wb_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipes(input logic v0, input int a0, input logic [31:0] d0,
                         input logic v1, input int a1, input logic [31:0] d1);
        logic [4:0] r0, r1;
        r0 = 5'(a0);
        r1 = 5'(a1);
        wb0_valid = v0; wb0_addr = MipsReg'(r0); wb0_data = d0; wb0_pc = 32'h100;
        wb1_valid = v1; wb1_addr = MipsReg'(r1); wb1_data = d1; wb1_pc = 32'h104;
    endtask

    task automatic lu(input logic v, input int a, input logic [31:0] d, input logic [31:0] pc);
        logic [4:0] r;
        r = 5'(a);
        lu_valid = v; lu_addr = MipsReg'(r); lu_data = d; lu_pc = pc;
    endtask

    task automatic do_reset();
        pipes(0, 0, 0, 0, 0, 0);
        lu(0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        pipes(0, 0, 0, 0, 0, 0);
        lu(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rw0", reg_write0, 0);
        chk("rst_rw1", reg_write1, 0);
        chk("rst_stall", wb_stall, 0);
        chk("rst_ready", lu_ready, 1);
        rst = 1'b0;

        // Asynchronous reset mid-cycle with a result buffered behind busy pipes
        pipes(1, 3, 32'h33, 1, 6, 32'h66);
        lu(1, 4, 32'h44, 32'h400);
        step();
        lu(0, 0, 0, 0);
        chk("pre_rst_rw0", reg_write0, 1);
        chk("pre_rst_d0", write_data0, 32'h33);
        chk("pre_rst_ready", lu_ready, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_rw0", reg_write0, 0);
        chk("arst_a0", write_addr0, 0);
        chk("arst_d0", write_data0, 0);
        chk("arst_pc0", pc0, 0);
        chk("arst_rw1", reg_write1, 0);
        chk("arst_d1", write_data1, 0);
        chk("arst_ready", lu_ready, 1);
        pipes(0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        step();
        chk("arst_drop_a", reg_write0, 0);
        step();
        chk("arst_drop_b", reg_write0, 0);
        chk("arst_drop_c", reg_write1, 0);

        // WAW between the pipes: port 1 wins
        do_reset();
        pipes(1, 5, 32'h11111111, 1, 5, 32'h22222222);
        step();
        pipes(0, 0, 0, 0, 0, 0);
        chk("waw_rw0", reg_write0, 0);
        chk("waw_rw1", reg_write1, 1);
        chk("waw_a1", write_addr1, 5);
        chk("waw_d1", write_data1, 32'h22222222);
        chk("waw_pc1", pc1, 32'h104);

        // Long-latency latency: accepted cycle 0, written cycle 2; wb0 to $0 ignored
        do_reset();
        lu(1, 7, 32'hAAAA0000, 32'h200);
        step();
        lu(0, 0, 0, 0);
        pipes(1, 0, 32'hDEAD, 0, 0, 0);
        chk("lat_c1_rw0", reg_write0, 0);
        step();
        pipes(0, 0, 0, 0, 0, 0);
        chk("lat_rw0", reg_write0, 1);
        chk("lat_a0", write_addr0, 7);
        chk("lat_d0", write_data0, 32'hAAAA0000);
        chk("lat_pc0", pc0, 32'h200);
        chk("lat_rw1", reg_write1, 0);
        step();
        chk("lat_zero_ign", reg_write0, 0);

        // Squash: buffered $9 overwritten by younger wb1 write
        do_reset();
        lu(1, 9, 32'h99, 32'h500);
        pipes(1, 1, 32'h1, 1, 2, 32'h2);
        step();
        lu(0, 0, 0, 0);
        pipes(1, 3, 32'h3, 1, 9, 32'h5);
        chk("sq_c1_a0", write_addr0, 1);
        chk("sq_c1_a1", write_addr1, 2);
        step();
        pipes(0, 0, 0, 0, 0, 0);
        chk("sq_rw1", reg_write1, 1);
        chk("sq_a1", write_addr1, 9);
        chk("sq_d1", write_data1, 32'h5);
        chk("sq_a0", write_addr0, 3);
        step();
        chk("sq_silent0", reg_write0, 0);
        chk("sq_silent1", reg_write1, 0);
        step();
        chk("sq_silent2", reg_write0, 0);

        // Starvation: pipes busy with a live entry buffered -> stall in cycle 5
        do_reset();
        lu(1, 8, 32'h88, 32'h600);
        pipes(1, 1, 32'h1, 1, 2, 32'h2);
        for (int c = 1; c <= 6; c++) begin
            step();
            lu(0, 0, 0, 0);
            if (c == 6) pipes(0, 0, 0, 0, 0, 0);
            chk($sformatf("stv_stall_c%0d", c), wb_stall, (c == 5) ? 1 : 0);
        end
        step();
        chk("stv_rw0", reg_write0, 1);
        chk("stv_a0", write_addr0, 8);
        chk("stv_d0", write_data0, 32'h88);
        chk("stv_rw1", reg_write1, 0);

        // Full FIFO back-pressure, then a two-entry drain in one cycle
        do_reset();
        lu(1, 10, 32'hA0, 32'h300);
        pipes(1, 1, 32'h1, 1, 2, 32'h2);
        chk("full_ready0", lu_ready, 1);
        step();
        lu(1, 11, 32'hB0, 32'h304);
        step();
        lu(1, 12, 32'hC0, 32'h308);
        chk("full_ready2", lu_ready, 0);
        step();
        pipes(0, 0, 0, 0, 0, 0);
        chk("full_ready3", lu_ready, 0);
        step();
        chk("drain_rw0", reg_write0, 1);
        chk("drain_a0", write_addr0, 10);
        chk("drain_d0", write_data0, 32'hA0);
        chk("drain_pc0", pc0, 32'h300);
        chk("drain_rw1", reg_write1, 1);
        chk("drain_a1", write_addr1, 11);
        chk("drain_d1", write_data1, 32'hB0);
        chk("drain_ready", lu_ready, 1);
        step();
        lu(0, 0, 0, 0);
        chk("held_c5_rw0", reg_write0, 0);
        chk("held_c5_rw1", reg_write1, 0);
        step();
        chk("held_rw0", reg_write0, 1);
        chk("held_a0", write_addr0, 12);
        chk("held_d0", write_data0, 32'hC0);
        chk("held_rw1", reg_write1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
